// File: rtl/adc_ctrl_pkg.sv
// Shared definitions for the ADC sampler controller: FSM encoding, LED source
// select codes, reset constants and the LED byte mux.
package adc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_AMP_SEND = 3'd1,
    ST_AMP_WAIT = 3'd2,
    ST_RUN      = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  localparam logic [2:0] SEL_A_LO   = 3'd0;
  localparam logic [2:0] SEL_A_HI   = 3'd1;
  localparam logic [2:0] SEL_B_LO   = 3'd2;
  localparam logic [2:0] SEL_B_HI   = 3'd3;
  localparam logic [2:0] SEL_AMP_RX = 3'd4;
  localparam logic [2:0] SEL_STATUS = 3'd5;

  localparam logic [7:0] RST_LED    = 8'hAA;
  localparam logic [7:0] DFLT_LED   = 8'h55;
  localparam logic [3:0] RST_GAIN_A = 4'b0001;
  localparam logic [3:0] RST_GAIN_B = 4'b0010;

  function automatic logic [7:0] led_byte(
    input logic [2:0]  sel,
    input logic [13:0] smp_a,
    input logic [13:0] smp_b,
    input logic [7:0]  rx,
    input logic        err,
    input logic [2:0]  st
  );
    logic [7:0] res;
    res = DFLT_LED;
    case (sel)
      SEL_A_LO:   res = smp_a[7:0];
      SEL_A_HI:   res = {2'b00, smp_a[13:8]};
      SEL_B_LO:   res = smp_b[7:0];
      SEL_B_HI:   res = {2'b00, smp_b[13:8]};
      SEL_AMP_RX: res = rx;
      SEL_STATUS: res = {err, 4'b0000, st};
      default:    res = DFLT_LED;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/adc_period_timer.sv
// Conversion trigger timer: pulses trig once every max(max,2) enabled cycles.
// The interval length is reloaded only while cleared and at each wrap.
module adc_period_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] max,
  output logic         trig
);

  logic [W-1:0] cnt;
  logic [W-1:0] lim;
  logic [W-1:0] max_clamped;

  assign max_clamped = (max < W'(2)) ? W'(2) : max;

  // A period change is only picked up here at the wrap, so a running interval always completes
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      lim  <= max_clamped;
      trig <= 1'b0;
    end else if (en) begin
      if (cnt == lim - W'(1)) begin
        cnt  <= '0;
        lim  <= max_clamped;
        trig <= 1'b1;
      end else begin
        cnt  <= cnt + W'(1);
        trig <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_sampler_ctrl.sv
// ADC sampler controller: programs the preamp, then triggers and captures ADC
// conversions. Define ADC_AVG_EN to average 2^AVG_LOG2 conversions per sample.
module adc_sampler_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int PW       = 32,
  parameter int AMP_TO   = 1024,
  parameter int AVG_LOG2 = 2
) (
  input  logic          CLK50MHZ,
  input  logic          RST,
  input  logic [PW-1:0] period,
  input  logic [3:0]    gain_a,
  input  logic [3:0]    gain_b,
  input  logic          gain_upd,
  output logic          amp_trig,
  output logic [3:0]    amp_a,
  output logic [3:0]    amp_b,
  input  logic          amp_done,
  input  logic [7:0]    amp_rx,
  output logic          adc_trig,
  input  logic          adc_done,
  input  logic [13:0]   adc_a,
  input  logic [13:0]   adc_b,
  input  logic [2:0]    sel,
  output logic [7:0]    led,
  output logic [13:0]   sample_a,
  output logic [13:0]   sample_b,
  output logic          sample_valid,
  output logic          amp_err
);

  localparam int WW = $clog2(AMP_TO + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(AMP_TO - 1);

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          tmr_clr;
  logic          tmr_en;
  logic          conv_ok;

  // Conversions are accepted only in RUN, even on the cycle gain_upd pulls us out of it
  assign conv_ok = adc_done && (state == ST_RUN);
  assign tmr_en  = (state == ST_RUN);
  assign tmr_clr = RST || (state != ST_RUN) || gain_upd;

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      state    <= ST_START;
      amp_a    <= RST_GAIN_A;
      amp_b    <= RST_GAIN_B;
      amp_trig <= 1'b0;
      amp_err  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      amp_trig <= 1'b0;
      case (state)
        ST_START: begin
          amp_a    <= gain_a;
          amp_b    <= gain_b;
          amp_trig <= 1'b1;
          state    <= ST_AMP_SEND;
        end
        ST_AMP_SEND: begin
          wait_cnt <= '0;
          state    <= ST_AMP_WAIT;
        end
        ST_AMP_WAIT: begin
          if (gain_upd) begin
            state <= ST_START;
          end else if (amp_done) begin
            state <= ST_RUN;
          end else if (wait_cnt == WAIT_LAST) begin
            amp_err <= 1'b1;
            state   <= ST_FAULT;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        ST_RUN: begin
          if (gain_upd) state <= ST_START;
        end
        ST_FAULT: begin
          if (gain_upd) begin
            amp_err <= 1'b0;
            state   <= ST_START;
          end
        end
        default: state <= ST_START;
      endcase
    end
  end

  adc_period_timer #(
    .W(PW)
  ) u_timer (
    .clk  (CLK50MHZ),
    .rst  (tmr_clr),
    .en   (tmr_en),
    .max  (period),
    .trig (adc_trig)
  );

`ifdef ADC_AVG_EN
  localparam int AW = 14 + AVG_LOG2;
  localparam logic [AVG_LOG2-1:0] AVG_LAST = '1;

  logic signed [AW-1:0] acc_a;
  logic signed [AW-1:0] acc_b;
  logic signed [AW-1:0] sum_a;
  logic signed [AW-1:0] sum_b;
  logic [AVG_LOG2-1:0]  avg_cnt;

  assign sum_a = acc_a + AW'($signed(adc_a));
  assign sum_b = acc_b + AW'($signed(adc_b));

  // Every pass through START restarts the averaging window from empty
  always_ff @(posedge CLK50MHZ) begin
    if (RST || state == ST_START) begin
      acc_a   <= '0;
      acc_b   <= '0;
      avg_cnt <= '0;
    end else if (conv_ok) begin
      if (avg_cnt == AVG_LAST) begin
        acc_a   <= '0;
        acc_b   <= '0;
        avg_cnt <= '0;
      end else begin
        acc_a   <= sum_a;
        acc_b   <= sum_b;
        avg_cnt <= avg_cnt + AVG_LOG2'(1);
      end
    end
  end

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      sample_a     <= '0;
      sample_b     <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= conv_ok && (avg_cnt == AVG_LAST);
      if (conv_ok && (avg_cnt == AVG_LAST)) begin
        sample_a <= 14'(sum_a >>> AVG_LOG2);
        sample_b <= 14'(sum_b >>> AVG_LOG2);
      end
    end
  end
`else
  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      sample_a     <= '0;
      sample_b     <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= conv_ok;
      if (conv_ok) begin
        sample_a <= adc_a;
        sample_b <= adc_b;
      end
    end
  end
`endif

  always_ff @(posedge CLK50MHZ) begin
    if (RST) begin
      led <= RST_LED;
    end else begin
      led <= led_byte(sel, sample_a, sample_b, amp_rx, amp_err, state);
    end
  end

endmodule

// File: tb/tb_adc_sampler_ctrl.sv
// Self-checking bench for adc_sampler_ctrl: randomized stimulus against a
// behavioural model of preamp handshake, trigger timing and sample capture.
module tb_adc_sampler_ctrl;

  localparam int PW       = 32;
  localparam int AMP_TO   = 1024;
  localparam int AVG_LOG2 = 2;
`ifdef ADC_AVG_EN
  localparam int DEPTH = 1 << AVG_LOG2;
`else
  localparam int DEPTH = 1;
`endif

  logic          CLK50MHZ;
  logic          RST;
  logic [PW-1:0] period;
  logic [3:0]    gain_a, gain_b;
  logic          gain_upd;
  logic          amp_trig;
  logic [3:0]    amp_a, amp_b;
  logic          amp_done;
  logic [7:0]    amp_rx;
  logic          adc_trig;
  logic          adc_done;
  logic [13:0]   adc_a, adc_b;
  logic [2:0]    sel;
  logic [7:0]    led;
  logic [13:0]   sample_a, sample_b;
  logic          sample_valid;
  logic          amp_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: running sums of the current averaging window
  int          sum_a_m, sum_b_m, cnt_m;
  logic [13:0] exp_sa, exp_sb;

  adc_sampler_ctrl #(.PW(PW), .AMP_TO(AMP_TO), .AVG_LOG2(AVG_LOG2)) dut (
    .CLK50MHZ(CLK50MHZ), .RST(RST), .period(period), .gain_a(gain_a), .gain_b(gain_b),
    .gain_upd(gain_upd), .amp_trig(amp_trig), .amp_a(amp_a), .amp_b(amp_b),
    .amp_done(amp_done), .amp_rx(amp_rx), .adc_trig(adc_trig), .adc_done(adc_done),
    .adc_a(adc_a), .adc_b(adc_b), .sel(sel), .led(led), .sample_a(sample_a),
    .sample_b(sample_b), .sample_valid(sample_valid), .amp_err(amp_err)
  );

  initial CLK50MHZ = 1'b0;
  always #10 CLK50MHZ = ~CLK50MHZ;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK50MHZ);
  endtask

  function automatic int exp_gap(input logic [PW-1:0] p);
    return (p < 2) ? 2 : int'(p);
  endfunction

  function automatic int floor_div(input int a, input int d);
    if (a >= 0) return a / d;
    return -((-a + d - 1) / d);
  endfunction

  function automatic logic [7:0] led_model(input logic [2:0] s, input logic [13:0] sa, input logic [13:0] sb,
                                           input logic [7:0] rx, input logic err, input logic [2:0] st);
    case (s)
      3'd0:    return sa[7:0];
      3'd1:    return {2'b00, sa[13:8]};
      3'd2:    return sb[7:0];
      3'd3:    return {2'b00, sb[13:8]};
      3'd4:    return rx;
      3'd5:    return {err, 4'b0000, st};
      default: return 8'h55;
    endcase
  endfunction

  task automatic model_reset();
    sum_a_m = 0; sum_b_m = 0; cnt_m = 0;
    exp_sa = '0; exp_sb = '0;
  endtask

  task automatic model_start();
    sum_a_m = 0; sum_b_m = 0; cnt_m = 0;
  endtask

  task automatic model_conv(input bit d, input logic [13:0] a, input logic [13:0] b, output bit v);
    v = 1'b0;
    if (d) begin
      sum_a_m += int'($signed(a));
      sum_b_m += int'($signed(b));
      cnt_m++;
      if (cnt_m == DEPTH) begin
        exp_sa = 14'(floor_div(sum_a_m, DEPTH));
        exp_sb = 14'(floor_div(sum_b_m, DEPTH));
        v = 1'b1;
        model_start();
      end
    end
  endtask

  task automatic do_reset();
    RST = 1'b1; gain_upd = 1'b0; amp_done = 1'b0; adc_done = 1'b0;
    tick(2);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic wait_amp_trig(output bit found);
    int k;
    k = 0;
    while (amp_trig !== 1'b1 && k < 8) begin tick(1); k++; end
    found = (amp_trig === 1'b1);
  endtask

  // Reset, let the preamp transfer finish 5 cycles after amp_trig, land in RUN
  task automatic enter_run(input logic [PW-1:0] p, input logic [3:0] ga, input logic [3:0] gb, output bit ok);
    period = p; gain_a = ga; gain_b = gb;
    do_reset();
    wait_amp_trig(ok);
    tick(4);
    amp_done = 1'b1;
    tick(1);
    amp_done = 1'b0;
    model_start();
  endtask

  task automatic measure_gap(output int n, output int amp_seen);
    n = 0; amp_seen = 0;
    do begin
      tick(1); n++;
      if (amp_trig === 1'b1) amp_seen++;
    end while (adc_trig !== 1'b1 && n < 200);
    if (adc_trig !== 1'b1) n = -1;
  endtask

  task automatic test_reset();
    gain_a = 4'($urandom_range(2, 15)); gain_b = 4'($urandom_range(3, 15));
    period = 32'($urandom_range(0, 20)); sel = 3'($urandom);
    adc_done = 1'b1; amp_done = 1'b1; gain_upd = 1'b1;
    adc_a = 14'($urandom); adc_b = 14'($urandom); amp_rx = 8'($urandom);
    RST = 1'b1;
    tick(3);
    n_checks++; if (led !== 8'hAA) $display("[TB] FAIL rst_led: got %h expected aa", led); else n_pass++;
    n_checks++; if (amp_a !== 4'b0001 || amp_b !== 4'b0010) $display("[TB] FAIL rst_gain: got %h/%h expected 1/2", amp_a, amp_b); else n_pass++;
    n_checks++; if (sample_a !== 14'd0 || sample_b !== 14'd0 || sample_valid !== 1'b0)
      $display("[TB] FAIL rst_sample: got %h/%h/%b expected 0/0/0", sample_a, sample_b, sample_valid); else n_pass++;
    n_checks++; if (amp_trig !== 1'b0 || adc_trig !== 1'b0 || amp_err !== 1'b0)
      $display("[TB] FAIL rst_flags: got %b%b%b expected 000", amp_trig, adc_trig, amp_err); else n_pass++;
    adc_done = 1'b0; amp_done = 1'b0; gain_upd = 1'b0; sel = 3'd5;
    RST = 1'b0;
    model_reset();
    tick(1);
    n_checks++; if (amp_trig !== 1'b1) $display("[TB] FAIL post_rst_trig: got %b expected 1", amp_trig); else n_pass++;
    n_checks++; if (amp_a !== gain_a || amp_b !== gain_b)
      $display("[TB] FAIL post_rst_gain: got %h/%h expected %h/%h", amp_a, amp_b, gain_a, gain_b); else n_pass++;
    n_checks++; if (led !== 8'h00) $display("[TB] FAIL led_start: got %h expected 00", led); else n_pass++;
    tick(1);
    n_checks++; if (amp_trig !== 1'b0) $display("[TB] FAIL trig_width: got %b expected 0", amp_trig); else n_pass++;
  endtask

  task automatic test_amp_handshake();
    bit ok;
    int n, seen, seen_total;
    logic [3:0] gb;
    gb = 4'($urandom);
    enter_run(32'd10, 4'd3, gb, ok);
    n_checks++; if (!ok) $display("[TB] FAIL hs_trig: got no amp_trig expected one"); else n_pass++;
    n_checks++; if (amp_a !== 4'd3 || amp_b !== gb) $display("[TB] FAIL hs_gain: got %h/%h expected 3/%h", amp_a, amp_b, gb); else n_pass++;
    seen_total = 0;
    for (int i = 0; i < 3; i++) begin
      measure_gap(n, seen);
      seen_total += seen;
      n_checks++; if (n !== 10) $display("[TB] FAIL hs_gap%0d: got %0d expected 10", i, n); else n_pass++;
    end
    n_checks++; if (seen_total !== 0) $display("[TB] FAIL hs_extra_amp_trig: got %0d expected 0", seen_total); else n_pass++;
  endtask

  task automatic test_timeout();
    bit ok;
    int k, adc_seen, sv_seen;
    logic [3:0] ng;
    gain_a = 4'($urandom); gain_b = 4'($urandom); period = 32'd3; sel = 3'd5;
    do_reset();
    wait_amp_trig(ok);
    n_checks++; if (!ok) $display("[TB] FAIL to_trig: got no amp_trig expected one"); else n_pass++;
    k = 0; adc_seen = 0;
    while (amp_err !== 1'b1 && k < AMP_TO + 20) begin
      tick(1); k++;
      if (adc_trig === 1'b1) adc_seen++;
    end
    n_checks++; if (k !== AMP_TO + 1) $display("[TB] FAIL to_latency: got %0d expected %0d", k, AMP_TO + 1); else n_pass++;
    n_checks++; if (adc_seen !== 0) $display("[TB] FAIL to_adc_trig: got %0d expected 0", adc_seen); else n_pass++;
    tick(1);
    n_checks++; if (led !== 8'h84) $display("[TB] FAIL fault_led: got %h expected 84", led); else n_pass++;
    adc_seen = 0; sv_seen = 0;
    for (int i = 0; i < 6; i++) begin
      adc_done = 1'b1; adc_a = 14'($urandom); adc_b = 14'($urandom);
      tick(1);
      if (adc_trig === 1'b1) adc_seen++;
      if (sample_valid === 1'b1) sv_seen++;
    end
    adc_done = 1'b0;
    n_checks++; if (adc_seen !== 0 || sv_seen !== 0)
      $display("[TB] FAIL fault_quiet: got adc_trig %0d valid %0d expected 0 0", adc_seen, sv_seen); else n_pass++;
    n_checks++; if (amp_err !== 1'b1) $display("[TB] FAIL err_sticky: got %b expected 1", amp_err); else n_pass++;
    ng = 4'($urandom);
    gain_a = ng; gain_upd = 1'b1;
    tick(1);
    gain_upd = 1'b0;
    model_start();
    n_checks++; if (amp_err !== 1'b0) $display("[TB] FAIL err_clear: got %b expected 0", amp_err); else n_pass++;
    tick(1);
    n_checks++; if (amp_trig !== 1'b1 || amp_a !== ng)
      $display("[TB] FAIL fault_retry: got trig %b gain %h expected 1 %h", amp_trig, amp_a, ng); else n_pass++;
  endtask

  task automatic test_period();
    logic [PW-1:0] plist [5];
    bit ok;
    int n, seen;
    plist[0] = 32'd0; plist[1] = 32'd1; plist[2] = 32'd2;
    plist[3] = 32'($urandom_range(3, 12)); plist[4] = 32'($urandom_range(3, 12));
    for (int p = 0; p < 5; p++) begin
      enter_run(plist[p], 4'($urandom), 4'($urandom), ok);
      n_checks++; if (!ok) $display("[TB] FAIL per_enter%0d: got no amp_trig expected one", p); else n_pass++;
      for (int i = 0; i < 3; i++) begin
        measure_gap(n, seen);
        n_checks++; if (n !== exp_gap(plist[p]))
          $display("[TB] FAIL per%0d_gap%0d: got %0d expected %0d", plist[p], i, n, exp_gap(plist[p])); else n_pass++;
      end
    end
    enter_run(32'd10, 4'($urandom), 4'($urandom), ok);
    measure_gap(n, seen);
    n_checks++; if (n !== 10) $display("[TB] FAIL chg_first: got %0d expected 10", n); else n_pass++;
    tick(3);
    period = 32'd4;
    measure_gap(n, seen);
    n_checks++; if (n !== 7) $display("[TB] FAIL chg_old_completes: got %0d expected 7", n); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      measure_gap(n, seen);
      n_checks++; if (n !== 4) $display("[TB] FAIL chg_new%0d: got %0d expected 4", i, n); else n_pass++;
    end
  endtask

  task automatic test_samples();
    bit ok, d, v;
    logic [7:0] led_exp;
    enter_run(32'd1000, 4'($urandom), 4'($urandom), ok);
    n_checks++; if (!ok) $display("[TB] FAIL smp_enter: got no amp_trig expected one"); else n_pass++;
    for (int i = 0; i < 24; i++) begin
      d = (i < 8) ? 1'b1 : ($urandom_range(0, 2) != 0);
      adc_done = d;
      adc_a = (i == 0) ? 14'h3FFF : 14'($urandom);
      adc_b = 14'($urandom);
      sel = (i == 1) ? 3'd1 : (i == 2) ? 3'd6 : 3'($urandom);
      amp_rx = 8'($urandom);
      led_exp = led_model(sel, exp_sa, exp_sb, amp_rx, 1'b0, 3'd3);
      tick(1);
      model_conv(d, adc_a, adc_b, v);
      n_checks++; if (sample_valid !== v) $display("[TB] FAIL smp_valid%0d: got %b expected %b", i, sample_valid, v); else n_pass++;
      n_checks++; if (sample_a !== exp_sa || sample_b !== exp_sb)
        $display("[TB] FAIL smp_data%0d: got %h/%h expected %h/%h", i, sample_a, sample_b, exp_sa, exp_sb); else n_pass++;
      n_checks++; if (led !== led_exp) $display("[TB] FAIL led%0d_sel%0d: got %h expected %h", i, sel, led, led_exp); else n_pass++;
    end
    adc_done = 1'b0;
  endtask

  task automatic test_wrong_state();
    bit ok;
    gain_a = 4'($urandom); gain_b = 4'($urandom); period = 32'd5;
    do_reset();
    wait_amp_trig(ok);
    tick(1);
    adc_done = 1'b1; adc_a = 14'($urandom_range(1, 8191)); adc_b = 14'($urandom_range(1, 8191));
    tick(1);
    adc_done = 1'b0;
    n_checks++; if (sample_valid !== 1'b0 || sample_a !== exp_sa)
      $display("[TB] FAIL wait_adc_done: got %b %h expected 0 %h", sample_valid, sample_a, exp_sa); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    bit ok, v;
    logic [13:0] va, vb;
    va = 14'($urandom_range(1, 8191)); vb = 14'($urandom_range(1, 8191));
    enter_run(32'd6, 4'($urandom), 4'($urandom), ok);
    for (int i = 0; i < DEPTH; i++) begin
      adc_done = 1'b1; adc_a = va; adc_b = vb;
      tick(1);
      model_conv(1'b1, va, vb, v);
    end
    adc_done = 1'b0;
    n_checks++; if (sample_a !== exp_sa || exp_sa !== va)
      $display("[TB] FAIL mid_capture: got %h expected %h", sample_a, va); else n_pass++;
    RST = 1'b1; adc_done = 1'b1; amp_done = 1'b1;
    tick(1);
    n_checks++; if (sample_a !== 14'd0 || sample_b !== 14'd0 || sample_valid !== 1'b0)
      $display("[TB] FAIL mid_rst_sample: got %h/%h/%b expected 0/0/0", sample_a, sample_b, sample_valid); else n_pass++;
    n_checks++; if (led !== 8'hAA || amp_a !== 4'b0001 || amp_b !== 4'b0010 || adc_trig !== 1'b0 || amp_trig !== 1'b0)
      $display("[TB] FAIL mid_rst_regs: got led %h gain %h/%h trig %b%b expected aa 1/2 00", led, amp_a, amp_b, adc_trig, amp_trig); else n_pass++;
    RST = 1'b0; sel = 3'd5;
    model_reset();
    tick(1);
    n_checks++; if (amp_trig !== 1'b1 || sample_valid !== 1'b0)
      $display("[TB] FAIL stray_start: got trig %b valid %b expected 1 0", amp_trig, sample_valid); else n_pass++;
    tick(1);
    amp_done = 1'b0; adc_done = 1'b0;
    tick(2);
    n_checks++; if (led !== 8'h02) $display("[TB] FAIL stray_amp_done: got %h expected 02", led); else n_pass++;
  endtask

  task automatic test_gain_upd_with_done();
    bit ok, v;
    logic [3:0] ng;
    enter_run(32'd50, 4'($urandom), 4'($urandom), ok);
    for (int i = 0; i < DEPTH - 1; i++) begin
      adc_done = 1'b1; adc_a = 14'($urandom); adc_b = 14'($urandom);
      tick(1);
      model_conv(1'b1, adc_a, adc_b, v);
      n_checks++; if (sample_valid !== v) $display("[TB] FAIL gu_pre%0d: got %b expected %b", i, sample_valid, v); else n_pass++;
    end
    ng = 4'($urandom);
    gain_a = ng; gain_upd = 1'b1;
    adc_done = 1'b1; adc_a = 14'($urandom); adc_b = 14'($urandom);
    tick(1);
    gain_upd = 1'b0; adc_done = 1'b0;
    model_conv(1'b1, adc_a, adc_b, v);
    model_start();
    n_checks++; if (sample_valid !== v || sample_a !== exp_sa || sample_b !== exp_sb)
      $display("[TB] FAIL gu_capture: got %b %h/%h expected %b %h/%h", sample_valid, sample_a, sample_b, v, exp_sa, exp_sb); else n_pass++;
    n_checks++; if (amp_trig !== 1'b0 || adc_trig !== 1'b0)
      $display("[TB] FAIL gu_start: got trig %b%b expected 00", amp_trig, adc_trig); else n_pass++;
    tick(1);
    n_checks++; if (amp_trig !== 1'b1 || amp_a !== ng)
      $display("[TB] FAIL gu_resend: got trig %b gain %h expected 1 %h", amp_trig, amp_a, ng); else n_pass++;
  endtask

  initial begin
    RST = 1'b1; period = '0; gain_a = '0; gain_b = '0; gain_upd = 1'b0; amp_done = 1'b0;
    amp_rx = '0; adc_done = 1'b0; adc_a = '0; adc_b = '0; sel = '0;
    model_reset();
    tick(1);
    test_reset();
    test_amp_handshake();
    test_timeout();
    test_period();
    test_samples();
    test_wrong_state();
    test_reset_mid_run();
    test_gain_upd_with_done();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adc_sampler_ctrl.md
ADC_SAMPLER_CTRL -- requirements
Module: adc_sampler_ctrl

Interface
REQ-001 Parameter PW, 32, width of the sample-period input.
REQ-002 Parameter AMP_TO, 1024, amp_done timeout in clock cycles.
REQ-003 Parameter AVG_LOG2, 2, log2 of the averaging depth (used only with ADC_AVG_EN).
REQ-004 CLK50MHZ  in  1  clock; reset RST, synchronous, active-high; clock CLK50MHZ.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 period  in  PW  ADC trigger period in clocks, sampled continuously.
REQ-007 gain_a, gain_b  in  4 each  requested preamp gain codes.
REQ-008 gain_upd  in  1  request to reprogram the preamp.
REQ-009 amp_trig  out  1  one-cycle start pulse to the preamp SPI driver.
REQ-010 amp_a, amp_b  out  4 each  latched gain codes presented to the preamp driver.
REQ-011 amp_done  in  1  preamp transfer complete, one-cycle pulse.
REQ-012 amp_rx  in  8  byte read back by the preamp driver.
REQ-013 adc_trig  out  1  one-cycle conversion start pulse.
REQ-014 adc_done  in  1  conversion complete; adc_a/adc_b valid in the same cycle.
REQ-015 adc_a, adc_b  in  14 each  signed two's-complement samples.
REQ-016 sel  in  3  LED source select.
REQ-017 led  out  8  registered display byte.
REQ-018 sample_a, sample_b  out  14 each  registered result samples.
REQ-019 sample_valid  out  1  one-cycle pulse when sample_a/sample_b update.
REQ-020 amp_err  out  1  sticky preamp timeout flag.

Function
REQ-021 FSM states: START, AMP_SEND, AMP_WAIT, RUN, FAULT.
REQ-022 START: latch gain_a/gain_b into amp_a/amp_b; go to AMP_SEND next cycle.
REQ-023 AMP_SEND: amp_trig=1 for exactly this one cycle; go to AMP_WAIT.
REQ-024 AMP_WAIT: on amp_done go to RUN; after AMP_TO cycles without amp_done, set amp_err and go to FAULT.
REQ-025 FAULT: adc_trig held 0; on gain_upd clear amp_err and go to START.
REQ-026 RUN: period counter clears on entry; adc_trig pulses once every max(period,2) cycles, with the first pulse max(period,2) cycles after entry.
REQ-027 A change to period in RUN takes effect at the next counter wrap.
REQ-028 In RUN or AMP_WAIT, gain_upd goes to START next cycle and clears the period counter; gain_upd in START or AMP_SEND is ignored.
REQ-029 adc_done is honoured only in RUN, including the same cycle gain_upd is seen; it is ignored in every other state.
REQ-030 An honoured adc_done yields sample_valid plus updated sample_a/sample_b one cycle later.
REQ-031 led updates every cycle from sel:
- 0: sample_a[7:0]
- 1: {2'b0, sample_a[13:8]}
- 2: sample_b[7:0]
- 3: {2'b0, sample_b[13:8]}
- 4: amp_rx
- 5: {amp_err, 4'b0, state[2:0]}
- 6-7: 8'h55

Reset
REQ-032 RST forces state=START.
REQ-033 RST forces amp_a=4'b0001, amp_b=4'b0010, led=8'hAA.
REQ-034 RST clears sample_a, sample_b, sample_valid, amp_trig, adc_trig, amp_err, the period counter and all accumulators.
REQ-035 RST asserted mid-transfer or mid-conversion aborts it; a later stray amp_done or adc_done is ignored until the matching state is reached.

Configuration
REQ-036 With macro ADC_AVG_EN defined:
- each channel sums 2^AVG_LOG2 honoured conversions in a signed (14+AVG_LOG2)-bit accumulator;
- the sum is then arithmetic-shifted right by AVG_LOG2 into sample_a/sample_b;
- sample_valid pulses once per 2^AVG_LOG2 conversions;
- accumulators and the sample count clear on entry to START.
REQ-037 Without ADC_AVG_EN, every honoured conversion is passed through unchanged and no accumulator logic exists.

Structure
REQ-038 Package adc_ctrl_pkg holds the FSM state encoding, the sel codes, and constants RST_LED=8'hAA, DFLT_LED=8'h55, RST_GAIN_A=4'b0001 and RST_GAIN_B=4'b0010.
REQ-039 The period counter SHALL be sub-module adc_period_timer, with ports clk, rst, en, max and trig.

Verification
REQ-040 Reset, gain_a=3, amp_done 5 cycles after amp_trig, period=10 -> one amp_trig with amp_a=3; adc_trig every 10 cycles, first at cycle 10 of RUN.
REQ-041 No amp_done -> amp_err=1 and FAULT after 1024 cycles with no adc_trig; then gain_upd -> amp_err=0, new amp_trig.
REQ-042 period=0 and period=1 -> adc_trig every 2 cycles; period changed 10->4 mid-count -> old interval completes, then 4.
REQ-043 adc_done with adc_a=14'h3FFF, sel=1 -> sample_valid next cycle, led=8'h3F; sel=6 -> 8'h55; adc_done in AMP_WAIT -> no sample_valid.
REQ-044 ADC_AVG_EN, AVG_LOG2=2, samples -4,-4,-4,0 -> one sample_valid, sample_a=-3 (14'h3FFD).
REQ-045 RST mid-RUN and gain_upd in the same cycle as adc_done -> reset values per REQ-032 to REQ-034; gain_upd case captures the sample, then re-enters START.
